rv_mem_bridge: RTL and testbench

Parametrised memory-bus bridge between the PicoRV32 native memory interface and up to eight slave ports. It decodes each core access against per-slave base/mask windows and registers the request toward the selected slave. It returns the slave's read data with a one-cycle registered response and turns unmapped or stalled accesses into an error response. It sits directly below the core wrapper and replaces point-to-point wiring of the core's memory bus.

---
 rtl/rv_bus_pkg.sv | 20 ++
 rtl/rv_addr_decoder.sv | 30 +++
 rtl/rv_mem_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_rv_mem_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_bus_pkg.sv
// rv_bus_pkg: shared types and constants for the rv_mem_bridge slice.
//   bridge_state_e : bridge FSM states (IDLE / ACTIVE / RESP)
//   MAX_SLV        : largest supported slave count
//   SEL_W          : width of a slave index
//   ERR_RDATA      : read data returned with an error response
//   TIMEOUT_W      : width of the optional slave wait counter
package rv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } bridge_state_e;

    localparam int          MAX_SLV   = 8;
    localparam int          SEL_W     = $clog2(MAX_SLV);
    localparam logic [31:0] ERR_RDATA = 32'h0;
    localparam int          TIMEOUT_W = 16;

endpackage

// File: rtl/rv_addr_decoder.sv
// rv_addr_decoder: combinational priority address decoder.
//   addr : request address
//   hit  : address falls inside at least one slave window
//   sel  : index of the lowest-numbered matching slave (0 when no hit)
// Slave i matches when (addr & SLV_MASK[i]) == SLV_BASE[i].
module rv_addr_decoder
    import rv_bus_pkg::*;
#(
    parameter int                     NUM_SLV  = 4,
    parameter logic [NUM_SLV*32-1:0]  SLV_BASE = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*32-1:0]  SLV_MASK = {NUM_SLV{32'h0}}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rv_mem_bridge.sv
// rv_mem_bridge: PicoRV32 native memory bus to NUM_SLV slave ports.
//   clk, resetn                        : clock, async active-low reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb : core request (wstrb 0 = read)
//   m_ready/m_rdata                    : one-cycle response strobe and data
//   s_valid (one-hot)/s_instr/s_addr/s_wdata/s_wstrb : registered slave request
//   s_ready/s_rdata                    : per-slave completion and packed read data
//   bus_err/err_addr                   : error pulse with m_ready, last errored address
// Optional feature macro: RV_MEM_BRIDGE_TIMEOUT_EN adds a slave wait timeout
// of TIMEOUT_CYC cycles; without it ACTIVE waits indefinitely.
//
// state  | meaning
// IDLE   | waiting for m_valid; decodes and accepts a request
// ACTIVE | request presented to the selected slave, waiting for its s_ready
// RESP   | m_ready (and bus_err on errors) driven for one cycle
module rv_mem_bridge
    import rv_bus_pkg::*;
#(
    parameter int                     NUM_SLV     = 4,
    parameter logic [NUM_SLV*32-1:0]  SLV_BASE    = {NUM_SLV{32'h0}},
    parameter logic [NUM_SLV*32-1:0]  SLV_MASK    = {NUM_SLV{32'h0}},
    parameter int                     TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   m_valid,
    input  logic                   m_instr,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_wstrb,
    output logic                   m_ready,
    output logic [31:0]            m_rdata,
    output logic [NUM_SLV-1:0]     s_valid,
    output logic                   s_instr,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wstrb,
    input  logic [NUM_SLV-1:0]     s_ready,
    input  logic [NUM_SLV*32-1:0]  s_rdata,
    output logic                   bus_err,
    output logic [31:0]            err_addr
);

    bridge_state_e        state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_SLV-1:0]   s_valid_q, s_valid_d;
    logic                 s_instr_q, s_instr_d;
    logic [31:0]          s_addr_q, s_addr_d;
    logic [31:0]          s_wdata_q, s_wdata_d;
    logic [3:0]           s_wstrb_q, s_wstrb_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 m_ready_q, m_ready_d;
    logic                 err_q, err_d;
    logic [31:0]          err_addr_q, err_addr_d;

    logic                 dec_hit;
    logic [SEL_W-1:0]     dec_sel;
    logic                 sel_ready;
    logic [31:0]          sel_rdata;

`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
    // Count value at which the current ACTIVE cycle is the TIMEOUT_CYC-th one.
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    rv_addr_decoder #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    // Only the selected port's completion and data are observed.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        s_valid_d  = s_valid_q;
        s_instr_d  = s_instr_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        rdata_d    = rdata_q;
        m_ready_d  = 1'b0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (dec_hit) begin
                        sel_d     = dec_sel;
                        s_instr_d = m_instr;
                        s_addr_d  = m_addr;
                        s_wdata_d = m_wdata;
                        s_wstrb_d = m_wstrb;
                        for (int i = 0; i < NUM_SLV; i++) begin
                            s_valid_d[i] = (dec_sel == SEL_W'(i));
                        end
`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                        state_d = ACTIVE;
                    end else begin
                        rdata_d    = ERR_RDATA;
                        err_d      = 1'b1;
                        m_ready_d  = 1'b1;
                        err_addr_d = m_addr;
                        state_d    = RESP;
                    end
                end
            end
            ACTIVE: begin
                // A completion in the timeout cycle still yields a normal response.
                if (sel_ready) begin
                    rdata_d   = sel_rdata;
                    s_valid_d = '0;
                    m_ready_d = 1'b1;
                    state_d   = RESP;
                end
`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    rdata_d    = ERR_RDATA;
                    s_valid_d  = '0;
                    err_d      = 1'b1;
                    m_ready_d  = 1'b1;
                    err_addr_d = s_addr_q;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                // m_valid is deliberately ignored here so a held request is not re-accepted.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            s_valid_q  <= '0;
            s_instr_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            rdata_q    <= '0;
            m_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            s_valid_q  <= s_valid_d;
            s_instr_q  <= s_instr_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            rdata_q    <= rdata_d;
            m_ready_q  <= m_ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign m_ready  = m_ready_q;
    assign m_rdata  = rdata_q;
    assign bus_err  = err_q;
    assign err_addr = err_addr_q;
    assign s_valid  = s_valid_q;
    assign s_instr  = s_instr_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;

endmodule

// File: tb/tb_rv_mem_bridge.sv
// tb_rv_mem_bridge: self-checking bench for rv_mem_bridge.
// A cycle-indexed expectation timeline is filled from the address windows and
// the requested slave wait states; a negedge process compares the DUT to it.
// Honours RV_MEM_BRIDGE_TIMEOUT_EN to choose the timeout or long-wait scenario.
module tb_rv_mem_bridge;

    localparam int           NSLV  = 3;
    localparam int           TO    = 8;
    localparam int           DEPTH = 512;
    // slave0 0x0000xxxx, slave1 0x1000xxxx, slave2 0x1xxxxxxx (overlaps slave1)
    localparam logic [95:0]  BASE  = {32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [95:0]  MASK  = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic               clk = 1'b0;
    logic               resetn;
    logic               m_valid, m_instr;
    logic [31:0]        m_addr, m_wdata;
    logic [3:0]         m_wstrb;
    logic               m_ready;
    logic [31:0]        m_rdata;
    logic [NSLV-1:0]    s_valid;
    logic               s_instr;
    logic [31:0]        s_addr, s_wdata;
    logic [3:0]         s_wstrb;
    logic [NSLV-1:0]    s_ready;
    logic [NSLV*32-1:0] s_rdata;
    logic               bus_err;
    logic [31:0]        err_addr;

    rv_mem_bridge #(
        .NUM_SLV     (NSLV),
        .SLV_BASE    (BASE),
        .SLV_MASK    (MASK),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .m_valid  (m_valid),
        .m_instr  (m_instr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .s_valid  (s_valid),
        .s_instr  (s_instr),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expected timeline, one entry per cycle.
    logic [NSLV-1:0] exp_sv [DEPTH];
    logic [31:0]     exp_sa [DEPTH];
    logic [31:0]     exp_sw [DEPTH];
    logic [3:0]      exp_ss [DEPTH];
    logic            exp_si [DEPTH];
    logic            exp_mr [DEPTH];
    logic            exp_er [DEPTH];
    logic [31:0]     exp_rd [DEPTH];
    logic [31:0]     exp_ea [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Lowest-index window containing addr, or -1.
    function automatic int model_target(input logic [31:0] addr);
        logic [95:0] b;
        logic [95:0] m;
        b = BASE;
        m = MASK;
        for (int i = 0; i < NSLV; i++) begin
            if ((addr & m[i*32 +: 32]) == b[i*32 +: 32]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NSLV*32-1:0] junk_rdata();
        logic [NSLV*32-1:0] r;
        for (int i = 0; i < NSLV; i++) r[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (cyc < DEPTH) begin
            chk("s_valid", 32'(s_valid), 32'(exp_sv[cyc]));
            chk("m_ready", 32'(m_ready), 32'(exp_mr[cyc]));
            chk("bus_err", 32'(bus_err), 32'(exp_er[cyc]));
            if (exp_mr[cyc]) chk("m_rdata", m_rdata, exp_rd[cyc]);
            if (exp_er[cyc]) chk("err_addr", err_addr, exp_ea[cyc]);
            if (exp_sv[cyc] != '0) begin
                chk("s_addr", s_addr, exp_sa[cyc]);
                chk("s_wdata", s_wdata, exp_sw[cyc]);
                chk("s_wstrb", 32'(s_wstrb), 32'(exp_ss[cyc]));
                chk("s_instr", 32'(s_instr), 32'(exp_si[cyc]));
            end
        end
    end

    function automatic void expect_active(input int k, input int t, input logic [31:0] a,
                                          input logic [31:0] w, input logic [3:0] s, input logic i);
        exp_sv[k] = NSLV'(1 << t);
        exp_sa[k] = a;
        exp_sw[k] = w;
        exp_ss[k] = s;
        exp_si[k] = i;
    endfunction

    // One core access, starting in the current cycle. The selected slave
    // completes after 'waits' wait states; other slaves pulse s_ready meanwhile.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic instr, input int waits, input logic [31:0] rd, input bit drop_early);
        int c, t, resp, rdy;
        bit err;
        c    = cyc;
        t    = model_target(addr);
        err  = (t < 0);
        rdy  = -1;
        resp = c + 1;
        if (t >= 0) begin
`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
            if (waits + 1 > TO) begin
                err  = 1'b1;
                resp = c + TO + 1;
            end else begin
                rdy  = c + 1 + waits;
                resp = rdy + 1;
            end
`else
            rdy  = c + 1 + waits;
            resp = rdy + 1;
`endif
            for (int k = c + 1; k < resp; k++) expect_active(k, t, addr, wdata, wstrb, instr);
        end
        exp_mr[resp] = 1'b1;
        exp_er[resp] = err;
        exp_rd[resp] = err ? 32'h0 : rd;
        exp_ea[resp] = addr;

        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        m_instr = instr;
        for (int cc = c + 1; cc <= resp + 1; cc++) begin
            @(posedge clk);
            #1;
            if (drop_early) m_valid = 1'b0;
            s_ready = '0;
            s_rdata = junk_rdata();
            if (t >= 0 && cc == rdy) begin
                s_ready[t]          = 1'b1;
                s_rdata[t*32 +: 32] = rd;
            end else if (t >= 0 && cc < resp) begin
                s_ready = ~NSLV'(1 << t);
            end
        end
        m_valid = 1'b0;
        s_ready = '0;
    endtask

    initial begin
        int c;
        for (int k = 0; k < DEPTH; k++) begin
            exp_sv[k] = '0; exp_sa[k] = '0; exp_sw[k] = '0; exp_ss[k] = '0; exp_si[k] = 1'b0;
            exp_mr[k] = 1'b0; exp_er[k] = 1'b0; exp_rd[k] = '0; exp_ea[k] = '0;
        end
        resetn  = 1'b0;
        m_valid = 1'b0;
        m_instr = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = junk_rdata();

        // Model pins: window priority and unmapped space.
        chk("model_overlap_sel", 32'(model_target(32'h1000_0000)), 32'd1);
        chk("model_slave2_sel",  32'(model_target(32'h1234_0000)), 32'd2);
        chk("model_unmapped",    32'(model_target(32'h8000_0000)), 32'hFFFF_FFFF);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_rdata",  m_rdata,  32'h0);
        chk("rst_s_addr",   s_addr,   32'h0);
        chk("rst_s_wdata",  s_wdata,  32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // zero-wait read from slave0
        do_req(32'h0000_0010, 32'h0, 4'b0000, 1'b0, 0, 32'h1234_5678, 1'b0);
        // write with 3 wait states at the slave1/slave2 overlap -> slave1
        do_req(32'h1000_0000, 32'hA5A5_A5A5, 4'b0011, 1'b0, 3, 32'h0BAD_F00D, 1'b0);
        // instruction fetch that only slave2 covers
        do_req(32'h1234_0008, 32'h0, 4'b0000, 1'b1, 1, 32'hCAFE_BABE, 1'b0);
        // unmapped read
        do_req(32'h8000_0000, 32'h0, 4'b0000, 1'b0, 0, 32'h0, 1'b0);
        chk("err_addr_unmapped", err_addr, 32'h8000_0000);
        // back-to-back; m_valid dropped during ACTIVE must not abort
        do_req(32'h0000_FFFC, 32'h1111_2222, 4'b1111, 1'b0, 2, 32'h5555_AAAA, 1'b1);
        do_req(32'h0000_0004, 32'h0, 4'b0000, 1'b0, 0, 32'h7777_8888, 1'b0);
        chk("err_addr_sticky", err_addr, 32'h8000_0000);
`ifdef RV_MEM_BRIDGE_TIMEOUT_EN
        do_req(32'h1000_0100, 32'h0, 4'b0000, 1'b0, 100, 32'h0, 1'b0);
        chk("err_addr_timeout", err_addr, 32'h1000_0100);
        do_req(32'h1000_0200, 32'h0, 4'b0000, 1'b0, TO - 1, 32'h600D_0001, 1'b0);
        chk("err_addr_after_late_ready", err_addr, 32'h1000_0100);
`else
        do_req(32'h1000_0100, 32'h0, 4'b0000, 1'b0, 20, 32'h1ABE_1ABE, 1'b0);
`endif

        // asynchronous reset in the middle of ACTIVE
        c = cyc;
        expect_active(c + 1, 0, 32'h0000_0020, 32'h0, 4'b0000, 1'b0);
        expect_active(c + 2, 0, 32'h0000_0020, 32'h0, 4'b0000, 1'b0);
        m_valid = 1'b1;
        m_addr  = 32'h0000_0020;
        m_wdata = 32'h0;
        m_wstrb = 4'b0000;
        m_instr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_s_valid", 32'(s_valid), 32'h0);
        chk("rst_async_m_ready", 32'(m_ready), 32'h0);
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_req(32'h0000_0030, 32'h0, 4'b0000, 1'b0, 1, 32'h4242_4242, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
